// File: rtl/uart_rx_packet_parser.sv
// Framed-byte parser (SYNC, CMD, LEN, payload, CSUM); Packet_Valid rises the cycle after a good CSUM byte.
// No RX backpressure: bytes during HOLD are dropped as overrun. UART_PARSER_TIMEOUT_EN adds an inter-byte timeout.
module uart_rx_packet_parser #(
  parameter int          MAX_LEN        = 16,
  parameter int          ADDR_WIDTH     = 4,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic [7:0]            RX_Data_in,
  input  logic                  RX_Data_Ready,
  input  logic                  Packet_Ack,
  input  logic [ADDR_WIDTH-1:0] Payload_Addr,
  output logic                  Packet_Valid,
  output logic [7:0]            Cmd_out,
  output logic [7:0]            Len_out,
  output logic [7:0]            Payload_Data,
  output logic                  Packet_Error,
  output logic [1:0]            Error_Code
);

  localparam int IW    = $clog2(MAX_LEN + 1);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = (ADDR_WIDTH > 8) ? ADDR_WIDTH : 8;

  localparam logic [1:0] ERR_TIMEOUT = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CSUM, S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      sum_q, sum_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic            buf_we;
  logic [7:0]      buf_q [DEPTH];
  logic            tmo_fire;

`ifdef UART_PARSER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d    = '0;
    tmo_fire = 1'b0;
    if (!RX_Data_Ready && (state_q inside {S_CMD, S_LEN, S_PAYLOAD, S_CSUM})) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) tmo_fire = 1'b1;
      else                                  tmo_d    = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_b) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    len_d   = len_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    code_d  = code_q;
    buf_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (RX_Data_Ready && RX_Data_in == SYNC_BYTE) state_d = S_CMD;
      end
      S_CMD: begin
        if (RX_Data_Ready) begin
          cmd_d   = RX_Data_in;
          sum_d   = RX_Data_in;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (RX_Data_Ready) begin
          if (RX_Data_in > 8'(MAX_LEN)) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = S_IDLE;
          end else begin
            len_d   = RX_Data_in;
            sum_d   = sum_q + RX_Data_in;
            idx_d   = '0;
            state_d = (RX_Data_in == 8'd0) ? S_CSUM : S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (RX_Data_Ready) begin
          buf_we = 1'b1;
          sum_d  = sum_q + RX_Data_in;
          idx_d  = idx_q + IW'(1);
          if ((8'(idx_q) + 8'd1) == len_q) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (RX_Data_Ready) begin
          if (RX_Data_in == sum_q) begin
            valid_d = 1'b1;
            state_d = S_HOLD;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CSUM;
            state_d = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        // Ack wins over a coincident byte: the byte is dropped silently.
        if (Packet_Ack) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (RX_Data_Ready) begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (tmo_fire) begin
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_b) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) buf_q[ADDR_WIDTH'(idx_q)] <= RX_Data_in;
  end

  assign Packet_Valid = valid_q;
  assign Cmd_out      = cmd_q;
  assign Len_out      = len_q;
  assign Packet_Error = err_q;
  assign Error_Code   = code_q;
  assign Payload_Data = (CW'(Payload_Addr) < CW'(len_q)) ? buf_q[Payload_Addr] : 8'h00;

endmodule

// File: tb/tb_uart_rx_packet_parser.sv
// Scoreboard bench for uart_rx_packet_parser: expected events queued at stimulus, matched on DUT strobes.
module tb_uart_rx_packet_parser;

  logic       clk = 1'b0;
  logic       reset_b;
  logic [7:0] RX_Data_in;
  logic       RX_Data_Ready;
  logic       Packet_Ack;
  logic [3:0] Payload_Addr;
  logic       Packet_Valid;
  logic [7:0] Cmd_out;
  logic [7:0] Len_out;
  logic [7:0] Payload_Data;
  logic       Packet_Error;
  logic [1:0] Error_Code;

  always #5 clk = ~clk;

  uart_rx_packet_parser #(
    .MAX_LEN(16), .ADDR_WIDTH(4), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .reset_b(reset_b), .RX_Data_in(RX_Data_in), .RX_Data_Ready(RX_Data_Ready),
    .Packet_Ack(Packet_Ack), .Payload_Addr(Payload_Addr), .Packet_Valid(Packet_Valid),
    .Cmd_out(Cmd_out), .Len_out(Len_out), .Payload_Data(Payload_Data),
    .Packet_Error(Packet_Error), .Error_Code(Error_Code)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_valid;
    logic [1:0] code;
    logic [7:0] cmd;
    logic [7:0] len;
  } exp_t;
  exp_t exp_q[$];
  bit   prev_v = 1'b0;

  task automatic push_err(input logic [1:0] c);
    exp_t e;
    e.is_valid = 1'b0; e.code = c; e.cmd = 8'h00; e.len = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic push_pkt(input logic [7:0] c, input logic [7:0] l);
    exp_t e;
    e.is_valid = 1'b1; e.code = 2'b00; e.cmd = c; e.len = l;
    exp_q.push_back(e);
  endtask

  // Monitor: every error strobe and every Packet_Valid rise must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (Packet_Error === 1'b1) begin
      checks++;
      if (exp_q.size() == 0 || exp_q[0].is_valid) begin
        errors++;
        $display("FAIL unexpected_error: got code %0d, expected no error", Error_Code);
      end else begin
        e = exp_q.pop_front();
        if (Error_Code !== e.code) begin
          errors++;
          $display("FAIL error_code: got %0d, expected %0d", Error_Code, e.code);
        end
      end
    end
    if (Packet_Valid === 1'b1 && !prev_v) begin
      checks++;
      if (exp_q.size() == 0 || !exp_q[0].is_valid) begin
        errors++;
        $display("FAIL unexpected_valid: got cmd %h len %h, expected no packet", Cmd_out, Len_out);
      end else begin
        e = exp_q.pop_front();
        if (Cmd_out !== e.cmd || Len_out !== e.len) begin
          errors++;
          $display("FAIL packet_hdr: got cmd %h len %h, expected cmd %h len %h",
                   Cmd_out, Len_out, e.cmd, e.len);
        end
      end
    end
    prev_v = (Packet_Valid === 1'b1);
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_Data_in    = b;
    RX_Data_Ready = 1'b1;
    @(posedge clk); #1;
    RX_Data_Ready = 1'b0;
  endtask

  task automatic ack();
    Packet_Ack = 1'b1;
    @(posedge clk); #1;
    Packet_Ack = 1'b0;
  endtask

  task automatic do_reset();
    reset_b = 1'b1;
    idle(2);
    reset_b = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    Payload_Addr = 4'd0; #1;
    checks++;
    if (Packet_Valid !== 1'b0 || Packet_Error !== 1'b0 || Error_Code !== 2'b00 ||
        Cmd_out !== 8'h00 || Len_out !== 8'h00 || Payload_Data !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: got valid %b err %b code %0d cmd %h len %h data %h, expected all 0",
               Packet_Valid, Packet_Error, Error_Code, Cmd_out, Len_out, Payload_Data);
    end
    sync();
  endtask

  task automatic test_good_packet();
    logic [7:0] exp_pay [3];
    exp_pay[0] = 8'h10; exp_pay[1] = 8'h20; exp_pay[2] = 8'h00;
    push_pkt(8'h01, 8'h02);
    send_byte(8'h3C); send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h33);
    checks++;
    if (Packet_Valid !== 1'b1) begin
      errors++; $display("FAIL good_valid: got %b, expected 1", Packet_Valid);
    end
    for (int i = 0; i < 3; i++) begin
      Payload_Addr = 4'(i); #1;
      checks++;
      if (Payload_Data !== exp_pay[i]) begin
        errors++; $display("FAIL good_payload[%0d]: got %h, expected %h", i, Payload_Data, exp_pay[i]);
      end
    end
    sync();
    ack();
    checks++;
    if (Packet_Valid !== 1'b0) begin
      errors++; $display("FAIL good_ack: valid got %b, expected 0", Packet_Valid);
    end
  endtask

  task automatic test_bad_csum();
    push_err(2'b10);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h34);
    idle(3);
    checks++;
    if (Packet_Valid !== 1'b0) begin
      errors++; $display("FAIL bad_csum_valid: got %b, expected 0", Packet_Valid);
    end
    push_pkt(8'h07, 8'h00);
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h07);
    Payload_Addr = 4'd0; #1;
    checks++;
    if (Packet_Valid !== 1'b1 || Len_out !== 8'h00 || Payload_Data !== 8'h00) begin
      errors++;
      $display("FAIL zero_len: got valid %b len %h data %h, expected 1 00 00", Packet_Valid, Len_out, Payload_Data);
    end
    sync();
    ack();
  endtask

  task automatic test_bad_len();
    push_err(2'b01);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h11);
    push_pkt(8'h01, 8'h01);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01); send_byte(8'h44); send_byte(8'h46);
    Payload_Addr = 4'd0; #1;
    checks++;
    if (Packet_Valid !== 1'b1 || Payload_Data !== 8'h44) begin
      errors++; $display("FAIL after_bad_len: got valid %b data %h, expected 1 44", Packet_Valid, Payload_Data);
    end
    sync();
    ack();
  endtask

  task automatic test_overrun_and_ack();
    push_pkt(8'h01, 8'h02);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h33);
    push_err(2'b11);
    send_byte(8'h55);
    idle(1);
    Payload_Addr = 4'd1; #1;
    checks++;
    if (Packet_Valid !== 1'b1 || Cmd_out !== 8'h01 || Len_out !== 8'h02 || Payload_Data !== 8'h20) begin
      errors++;
      $display("FAIL overrun_hold: got valid %b cmd %h len %h data %h, expected 1 01 02 20",
               Packet_Valid, Cmd_out, Len_out, Payload_Data);
    end
    sync();
    // Byte coincident with ack: ack honoured, byte dropped without error.
    RX_Data_in = 8'h77; RX_Data_Ready = 1'b1; Packet_Ack = 1'b1;
    @(posedge clk); #1;
    RX_Data_Ready = 1'b0; Packet_Ack = 1'b0;
    checks++;
    if (Packet_Valid !== 1'b0) begin
      errors++; $display("FAIL ack_with_byte: valid got %b, expected 0", Packet_Valid);
    end
    // Ack mid-packet is ignored.
    push_pkt(8'h01, 8'h02);
    send_byte(8'hA5); send_byte(8'h01);
    ack();
    send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h33);
    checks++;
    if (Packet_Valid !== 1'b1) begin
      errors++; $display("FAIL ack_outside_hold: valid got %b, expected 1", Packet_Valid);
    end
    ack();
  endtask

  task automatic test_reset_mid();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h10);
    do_reset();
    Payload_Addr = 4'd0; #1;
    checks++;
    if (Packet_Valid !== 1'b0 || Cmd_out !== 8'h00 || Len_out !== 8'h00 || Payload_Data !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: got valid %b cmd %h len %h data %h, expected all 0",
               Packet_Valid, Cmd_out, Len_out, Payload_Data);
    end
    sync();
    push_pkt(8'h01, 8'h02);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h33);
    do_reset();
    checks++;
    if (Packet_Valid !== 1'b0 || Len_out !== 8'h00) begin
      errors++; $display("FAIL reset_hold: got valid %b len %h, expected 0 00", Packet_Valid, Len_out);
    end
  endtask

  task automatic test_timeout();
    send_byte(8'hA5); send_byte(8'h01);
`ifdef UART_PARSER_TIMEOUT_EN
    push_err(2'b00);
    idle(60);
    push_pkt(8'h01, 8'h02);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
`else
    idle(60);
    checks++;
    if (Packet_Valid !== 1'b0) begin
      errors++; $display("FAIL no_timeout_valid: got %b, expected 0", Packet_Valid);
    end
    push_pkt(8'h01, 8'h02);
    send_byte(8'h02);
`endif
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h33);
    checks++;
    if (Packet_Valid !== 1'b1) begin
      errors++; $display("FAIL after_timeout_window: valid got %b, expected 1", Packet_Valid);
    end
    ack();
  endtask

  task automatic test_back_to_back();
    logic [7:0] pay [16];
    logic [7:0] cmd, len, sum, want;
    for (int p = 0; p < 8; p++) begin
      cmd = 8'($urandom_range(0, 255));
      len = (p == 0) ? 8'd16 : 8'($urandom_range(0, 16));
      sum = cmd + len;
      for (int i = 0; i < 16; i++) begin
        pay[i] = 8'($urandom_range(0, 255));
        if (i < int'(len)) sum = sum + pay[i];
      end
      push_pkt(cmd, len);
      send_byte(8'hA5); send_byte(cmd); send_byte(len);
      for (int i = 0; i < int'(len); i++) send_byte(pay[i]);
      send_byte(sum);
      for (int i = 0; i < 16; i++) begin
        want = (i < int'(len)) ? pay[i] : 8'h00;
        Payload_Addr = 4'(i); #1;
        checks++;
        if (Payload_Data !== want) begin
          errors++;
          $display("FAIL b2b_payload p%0d[%0d]: got %h, expected %h", p, i, Payload_Data, want);
        end
      end
      sync();
      ack();
    end
  endtask

  initial begin
    reset_b = 1'b1; RX_Data_in = 8'h00; RX_Data_Ready = 1'b0;
    Packet_Ack = 1'b0; Payload_Addr = 4'd0;
    sync();
    test_reset();
    test_good_packet();
    test_bad_csum();
    test_bad_len();
    test_overrun_and_ack();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    idle(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL pending_events: %0d expected events never seen, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
